weight_bank_regfile: RTL and testbench



---
 rtl/weight_bank_regfile.sv | 149 ++++++++++++++
 tb/tb_weight_bank_regfile.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bank_regfile.sv
// Shadow/active weight bank: captures steered weight/bias beats into a shadow bank, copies to active on swap.
// Optional beat counter on debug_beat_cnt when WEIGHT_BANK_DEBUG_CNT_EN is defined (tied to 0 otherwise).
module weight_bank_regfile #(
    parameter int WEIGHT_WIDTH = 16,
    parameter int PE_CORE_NUM  = 16,
    parameter int DATA_WIDTH   = PE_CORE_NUM * WEIGHT_WIDTH,
    parameter int GROUP_NUM    = 8,
    parameter int KERNEL_TAPS  = 9
) (
    input  logic                            system_clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           weight_bias_data,
    input  logic [GROUP_NUM:0]              weight_bias_valid,
    input  logic                            bank_swap_req,
    output logic                            bank_swap_ack,
    output logic [GROUP_NUM:0]              shadow_loaded_mask,
    input  logic [3:0]                      rd_tap,
    output logic [GROUP_NUM*DATA_WIDTH-1:0] weight_out,
    output logic [DATA_WIDTH-1:0]           bias_out,
    output logic                            protocol_err,
    output logic [31:0]                     debug_beat_cnt
);

    localparam int GRP_W = $clog2(GROUP_NUM);
    localparam int TAP_W = 4;
    localparam int VLD_W = GROUP_NUM + 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL_TAPS - 1);

    logic [DATA_WIDTH-1:0] shadow_w [GROUP_NUM][KERNEL_TAPS];
    logic [DATA_WIDTH-1:0] active_w [GROUP_NUM][KERNEL_TAPS];
    logic [DATA_WIDTH-1:0] shadow_bias;
    logic [DATA_WIDTH-1:0] active_bias;

    logic [TAP_W-1:0] tap_cnt;
    logic [GRP_W-1:0] last_grp;
    logic [GRP_W-1:0] grp;
    logic [TAP_W-1:0] wr_tap;
    logic             any_valid;
    logic             multi_hot;
    logic             weight_beat;
    logic             bias_beat;
    logic             grp_switch;
    logic             grant;

    always_comb begin
        grp = '0;
        for (int i = 0; i < GROUP_NUM; i++) begin
            if (weight_bias_valid[i]) grp = GRP_W'(i);
        end
    end

    assign any_valid   = |weight_bias_valid;
    assign multi_hot   = |(weight_bias_valid & (weight_bias_valid - VLD_W'(1)));
    assign bias_beat   = (weight_bias_valid == {1'b1, {GROUP_NUM{1'b0}}});
    assign weight_beat = any_valid && !multi_hot && !weight_bias_valid[GROUP_NUM];
    assign grp_switch  = weight_beat && (grp != last_grp) && (tap_cnt != '0);
    // A group change mid-load restarts the new group at tap 0.
    assign wr_tap      = grp_switch ? '0 : tap_cnt;
    assign grant       = bank_swap_req && (tap_cnt == '0) && !any_valid;

    assign bank_swap_ack = grant;
    assign bias_out      = active_bias;

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt            <= '0;
            last_grp           <= '0;
            shadow_loaded_mask <= '0;
            protocol_err       <= 1'b0;
        end else begin
            if (multi_hot || grp_switch || (bias_beat && tap_cnt != '0)) begin
                protocol_err <= 1'b1;
            end
            if (grant) begin
                shadow_loaded_mask <= '0;
            end else if (weight_beat) begin
                last_grp <= grp;
                if (wr_tap == LAST_TAP) begin
                    tap_cnt                 <= '0;
                    shadow_loaded_mask[grp] <= 1'b1;
                end else begin
                    tap_cnt <= wr_tap + TAP_W'(1);
                end
            end else if (bias_beat) begin
                shadow_loaded_mask[GROUP_NUM] <= 1'b1;
            end
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < GROUP_NUM; g++) begin
                for (int t = 0; t < KERNEL_TAPS; t++) begin
                    shadow_w[g][t] <= '0;
                end
            end
            shadow_bias <= '0;
        end else begin
            if (weight_beat) shadow_w[grp][wr_tap] <= weight_bias_data;
            if (bias_beat)   shadow_bias <= weight_bias_data;
        end
    end

    // Whole-bank copy: groups not reloaded carry their previous shadow contents forward.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < GROUP_NUM; g++) begin
                for (int t = 0; t < KERNEL_TAPS; t++) begin
                    active_w[g][t] <= '0;
                end
            end
            active_bias <= '0;
        end else if (grant) begin
            active_w    <= shadow_w;
            active_bias <= shadow_bias;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_out <= '0;
        end else begin
            for (int g = 0; g < GROUP_NUM; g++) begin
                weight_out[g*DATA_WIDTH +: DATA_WIDTH] <=
                    (rd_tap <= LAST_TAP) ? active_w[g][rd_tap] : '0;
            end
        end
    end

`ifdef WEIGHT_BANK_DEBUG_CNT_EN
    logic [31:0] beat_cnt;
    logic        beat_accepted;

    assign beat_accepted = weight_beat || bias_beat;

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (beat_accepted && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end

    assign debug_beat_cnt = beat_cnt;
`else
    assign debug_beat_cnt = '0;
`endif

endmodule

// File: tb/tb_weight_bank_regfile.sv
// Directed bench for weight_bank_regfile: loads, swaps, read-back, protocol errors and reset.
module tb_weight_bank_regfile;

    localparam int DW = 256;
    localparam int GN = 8;
`ifdef WEIGHT_BANK_DEBUG_CNT_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic              system_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     weight_bias_data = '0;
    logic [GN:0]       weight_bias_valid = '0;
    logic              bank_swap_req = 1'b0;
    logic              bank_swap_ack;
    logic [GN:0]       shadow_loaded_mask;
    logic [3:0]        rd_tap = '0;
    logic [GN*DW-1:0]  weight_out;
    logic [DW-1:0]     bias_out;
    logic              protocol_err;
    logic [31:0]       debug_beat_cnt;

    int checks = 0;
    int failures = 0;

    localparam logic [DW-1:0] BIAS_A5 = {32{8'hA5}};

    weight_bank_regfile dut (
        .system_clk        (system_clk),
        .rst_n             (rst_n),
        .weight_bias_data  (weight_bias_data),
        .weight_bias_valid (weight_bias_valid),
        .bank_swap_req     (bank_swap_req),
        .bank_swap_ack     (bank_swap_ack),
        .shadow_loaded_mask(shadow_loaded_mask),
        .rd_tap            (rd_tap),
        .weight_out        (weight_out),
        .bias_out          (bias_out),
        .protocol_err      (protocol_err),
        .debug_beat_cnt    (debug_beat_cnt)
    );

    always #5 system_clk = ~system_clk;

    function automatic logic [DW-1:0] wdat(input int g, input int t, input logic [3:0] tag);
        return {16{tag, 4'(g), 8'(t)}};
    endfunction

    task automatic step();
        @(posedge system_clk);
        #1;
    endtask

    task automatic beat(input logic [GN:0] v, input logic [DW-1:0] d);
        weight_bias_valid = v;
        weight_bias_data  = d;
        step();
        weight_bias_valid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bank_swap_req = 1'b0;
        weight_bias_valid = '0;
        rd_tap = '0;
        #12;
        @(negedge system_clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (weight_out !== '0 || bias_out !== '0) begin
            failures++;
            $display("FAIL reset_data weight_out_nz=%0b bias_out=%h required zero", |weight_out, bias_out);
        end
        checks++;
        if (shadow_loaded_mask !== 9'h000 || bank_swap_ack !== 1'b0 || protocol_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl mask=%h ack=%b err=%b required 000/0/0",
                     shadow_loaded_mask, bank_swap_ack, protocol_err);
        end
        checks++;
        if (debug_beat_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_dbg got=%0d required 0", debug_beat_cnt);
        end
    endtask

    task automatic test_group0_swap();
        for (int t = 0; t < 9; t++) beat(9'h001, DW'(t));
        checks++;
        if (shadow_loaded_mask !== 9'h001) begin
            failures++;
            $display("FAIL g0_mask_pre got=%h required 001", shadow_loaded_mask);
        end
        checks++;
        if (debug_beat_cnt !== (DBG_EN ? 32'd9 : 32'd0)) begin
            failures++;
            $display("FAIL g0_dbg got=%0d required %0d", debug_beat_cnt, DBG_EN ? 9 : 0);
        end
        bank_swap_req = 1'b1;
        #1;
        checks++;
        if (bank_swap_ack !== 1'b1) begin
            failures++;
            $display("FAIL g0_ack got=%b required 1", bank_swap_ack);
        end
        step();
        bank_swap_req = 1'b0;
        #1;
        checks++;
        if (bank_swap_ack !== 1'b0 || shadow_loaded_mask !== 9'h000) begin
            failures++;
            $display("FAIL g0_after_swap ack=%b mask=%h required 0/000", bank_swap_ack, shadow_loaded_mask);
        end
        for (int t = 0; t < 9; t++) begin
            rd_tap = 4'(t);
            step();
            checks++;
            if (weight_out[DW-1:0] !== DW'(t)) begin
                failures++;
                $display("FAIL g0_read tap=%0d got=%h required %0d", t, weight_out[DW-1:0], t);
            end
        end
    endtask

    task automatic test_full_reload();
        int acks;
        logic [GN*DW-1:0] exp;
        acks = 0;
        bank_swap_req = 1'b1;
        for (int g = 0; g < GN; g++) begin
            for (int t = 0; t < 9; t++) begin
                weight_bias_valid = 9'(1 << g);
                weight_bias_data  = wdat(g, t, 4'hC);
                #1;
                if (bank_swap_ack) acks++;
                step();
            end
        end
        weight_bias_valid = 9'h100;
        weight_bias_data  = BIAS_A5;
        #1;
        if (bank_swap_ack) acks++;
        step();
        weight_bias_valid = '0;
        #1;
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL full_early_ack got=%0d required 0", acks);
        end
        checks++;
        if (shadow_loaded_mask !== 9'h1FF) begin
            failures++;
            $display("FAIL full_mask_pre got=%h required 1ff", shadow_loaded_mask);
        end
        checks++;
        if (bank_swap_ack !== 1'b1) begin
            failures++;
            $display("FAIL full_ack got=%b required 1", bank_swap_ack);
        end
        step();
        bank_swap_req = 1'b0;
        #1;
        checks++;
        if (bias_out !== BIAS_A5 || shadow_loaded_mask !== 9'h000) begin
            failures++;
            $display("FAIL full_bias got=%h mask=%h required a5../000", bias_out, shadow_loaded_mask);
        end
        checks++;
        if (protocol_err !== 1'b0) begin
            failures++;
            $display("FAIL full_err got=%b required 0", protocol_err);
        end
        checks++;
        if (debug_beat_cnt !== (DBG_EN ? 32'd82 : 32'd0)) begin
            failures++;
            $display("FAIL full_dbg got=%0d required %0d", debug_beat_cnt, DBG_EN ? 82 : 0);
        end
        rd_tap = 4'd4;
        step();
        for (int g = 0; g < GN; g++) exp[g*DW +: DW] = wdat(g, 4, 4'hC);
        checks++;
        if (weight_out !== exp) begin
            failures++;
            $display("FAIL full_read_tap4 got_g0=%h required %h", weight_out[DW-1:0], exp[DW-1:0]);
        end
    endtask

    task automatic test_swap_wait();
        int acks;
        acks = 0;
        for (int t = 0; t < 4; t++) beat(9'h008, wdat(3, t, 4'h3));
        bank_swap_req = 1'b1;
        #1;
        checks++;
        if (bank_swap_ack !== 1'b0) begin
            failures++;
            $display("FAIL wait_mid_load_ack got=%b required 0", bank_swap_ack);
        end
        step();
        for (int t = 4; t < 9; t++) begin
            weight_bias_valid = 9'h008;
            weight_bias_data  = wdat(3, t, 4'h3);
            #1;
            if (bank_swap_ack) acks++;
            step();
        end
        weight_bias_valid = '0;
        #1;
        checks++;
        if (acks != 0 || bank_swap_ack !== 1'b1) begin
            failures++;
            $display("FAIL wait_ack early=%0d now=%b required 0/1", acks, bank_swap_ack);
        end
        step();
        bank_swap_req = 1'b0;
        rd_tap = 4'd8;
        step();
        checks++;
        if (weight_out[3*DW +: DW] !== wdat(3, 8, 4'h3)) begin
            failures++;
            $display("FAIL wait_g3_read got=%h required %h", weight_out[3*DW +: DW], wdat(3, 8, 4'h3));
        end
        checks++;
        if (weight_out[2*DW +: DW] !== wdat(2, 8, 4'hC)) begin
            failures++;
            $display("FAIL wait_g2_kept got=%h required %h", weight_out[2*DW +: DW], wdat(2, 8, 4'hC));
        end
    endtask

    task automatic test_rd_oob();
        rd_tap = 4'd9;
        step();
        checks++;
        if (weight_out !== '0) begin
            failures++;
            $display("FAIL oob_tap9 got_g0=%h required 0", weight_out[DW-1:0]);
        end
        rd_tap = 4'd15;
        step();
        checks++;
        if (weight_out !== '0) begin
            failures++;
            $display("FAIL oob_tap15 got_g0=%h required 0", weight_out[DW-1:0]);
        end
        rd_tap = 4'd0;
        step();
        checks++;
        if (weight_out[DW-1:0] !== wdat(0, 0, 4'hC)) begin
            failures++;
            $display("FAIL oob_recover got=%h required %h", weight_out[DW-1:0], wdat(0, 0, 4'hC));
        end
    endtask

    task automatic test_reset_midload();
        for (int t = 0; t < 5; t++) beat(9'h002, wdat(1, t, 4'h7));
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (weight_out !== '0 || bias_out !== '0) begin
            failures++;
            $display("FAIL rst_mid_data weight_out_nz=%0b bias_out=%h required zero", |weight_out, bias_out);
        end
        checks++;
        if (shadow_loaded_mask !== 9'h000 || protocol_err !== 1'b0 || bank_swap_ack !== 1'b0
            || debug_beat_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_ctrl mask=%h err=%b ack=%b dbg=%0d required all 0",
                     shadow_loaded_mask, protocol_err, bank_swap_ack, debug_beat_cnt);
        end
        @(negedge system_clk);
        rst_n = 1'b1;
        step();
        bank_swap_req = 1'b1;
        #1;
        checks++;
        if (bank_swap_ack !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_swap_ack got=%b required 1", bank_swap_ack);
        end
        step();
        bank_swap_req = 1'b0;
        rd_tap = 4'd2;
        step();
        checks++;
        if (weight_out !== '0) begin
            failures++;
            $display("FAIL rst_mid_read got_g1=%h required 0", weight_out[DW +: DW]);
        end
    endtask

    task automatic test_group_change();
        for (int t = 0; t < 5; t++) beat(9'h004, wdat(2, t, 4'h9));
        checks++;
        if (protocol_err !== 1'b0) begin
            failures++;
            $display("FAIL chg_err_before got=%b required 0", protocol_err);
        end
        beat(9'h010, wdat(4, 0, 4'hE));
        checks++;
        if (protocol_err !== 1'b1) begin
            failures++;
            $display("FAIL chg_err got=%b required 1", protocol_err);
        end
        for (int t = 1; t < 8; t++) beat(9'h010, wdat(4, t, 4'hE));
        checks++;
        if (shadow_loaded_mask !== 9'h000) begin
            failures++;
            $display("FAIL chg_mask_7 got=%h required 000", shadow_loaded_mask);
        end
        beat(9'h010, wdat(4, 8, 4'hE));
        checks++;
        if (shadow_loaded_mask !== 9'h010) begin
            failures++;
            $display("FAIL chg_mask_8 got=%h required 010", shadow_loaded_mask);
        end
        checks++;
        if (debug_beat_cnt !== (DBG_EN ? 32'd14 : 32'd0)) begin
            failures++;
            $display("FAIL chg_dbg got=%0d required %0d", debug_beat_cnt, DBG_EN ? 14 : 0);
        end
        bank_swap_req = 1'b1;
        step();
        bank_swap_req = 1'b0;
        rd_tap = 4'd0;
        step();
        checks++;
        if (weight_out[4*DW +: DW] !== wdat(4, 0, 4'hE)) begin
            failures++;
            $display("FAIL chg_g4_tap0 got=%h required %h", weight_out[4*DW +: DW], wdat(4, 0, 4'hE));
        end
    endtask

    task automatic test_invalid();
        do_reset();
        beat(9'h003, '1);
        checks++;
        if (protocol_err !== 1'b1) begin
            failures++;
            $display("FAIL inv_err got=%b required 1", protocol_err);
        end
        checks++;
        if (shadow_loaded_mask !== 9'h000 || debug_beat_cnt !== 32'd0) begin
            failures++;
            $display("FAIL inv_state mask=%h dbg=%0d required 000/0", shadow_loaded_mask, debug_beat_cnt);
        end
        bank_swap_req = 1'b1;
        #1;
        checks++;
        if (bank_swap_ack !== 1'b1) begin
            failures++;
            $display("FAIL inv_swap_ack got=%b required 1", bank_swap_ack);
        end
        step();
        bank_swap_req = 1'b0;
        rd_tap = 4'd0;
        step();
        checks++;
        if (weight_out !== '0) begin
            failures++;
            $display("FAIL inv_shadow got_g0=%h g1=%h required 0", weight_out[DW-1:0], weight_out[DW +: DW]);
        end
    endtask

    initial begin
        test_reset();
        test_group0_swap();
        test_full_reload();
        test_swap_wait();
        test_rd_oob();
        test_reset_midload();
        test_group_change();
        test_invalid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
